// File: rtl/vga_layer_mixer.sv
// N-layer VGA compositor: aligns per-layer pixels of differing latency, resolves
// priority and colour-key transparency, and emits the pixel with matching delayed timing.
module vga_layer_mixer #(
  parameter int                    N_LAYERS  = 4,
  parameter int                    RGB_W     = 12,
  parameter int                    CNT_W     = 11,
  parameter int                    MAX_LAT   = 3,
  parameter logic [3*N_LAYERS-1:0] LAYER_LAT = {N_LAYERS{3'd0}},
  parameter int                    BG_LAT    = 0,
  parameter bit                    KEY_EN    = 1'b1,
  parameter logic [RGB_W-1:0]      KEY_COLOR = 12'h0F0,
  parameter logic [N_LAYERS-1:0]   EN_RESET  = '1,
  localparam int                   ID_W      = $clog2(N_LAYERS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          hcount_in,
  input  logic [CNT_W-1:0]          vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      hblnk_in,
  input  logic                      vblnk_in,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_valid,
  input  logic [N_LAYERS-1:0]       layer_en_req,
  output logic [CNT_W-1:0]          hcount_out,
  output logic [CNT_W-1:0]          vcount_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      hblnk_out,
  output logic                      vblnk_out,
  output logic [RGB_W-1:0]          rgb_out,
  output logic [ID_W-1:0]           top_id,
  output logic [N_LAYERS-1:0]       layer_en_active,
  output logic                      frame_start
);

  localparam int TW    = 2 * CNT_W + 4;
  localparam int BG_D  = MAX_LAT - BG_LAT;

  if (MAX_LAT < 1 || MAX_LAT > 7) begin : g_bad_max_lat
    $error("vga_layer_mixer: MAX_LAT must be in 1..7");
  end
  if (BG_LAT > MAX_LAT) begin : g_bad_bg_lat
    $error("vga_layer_mixer: BG_LAT exceeds MAX_LAT");
  end

  // Timing delay line: MAX_LAT stages here, the compositing register adds the last one.
  logic [TW-1:0] w_tim_in;
  logic [TW-1:0] r_tim [MAX_LAT];
  logic [TW-1:0] w_tim_al;

  assign w_tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: delay lines are plain flops, so clearing them on reset is cheap and makes
      // the refill after reset deterministic (blank-free zero pixels, background colour 0).
      for (int k = 0; k < MAX_LAT; k++) r_tim[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous stage's old
      // value on the same edge; blocking here would collapse the shift register.
      r_tim[0] <= w_tim_in;
      for (int k = 1; k < MAX_LAT; k++) r_tim[k] <= r_tim[k-1];
    end
  end

  assign w_tim_al = r_tim[MAX_LAT-1];

  // Background alignment.
  logic [RGB_W-1:0] w_bg_al;

  if (BG_D <= 0) begin : g_bg_wire
    assign w_bg_al = bg_rgb;
  end else begin : g_bg_pipe
    logic [RGB_W-1:0] r_pipe [BG_D];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < BG_D; k++) r_pipe[k] <= '0;
      end else begin
        r_pipe[0] <= bg_rgb;
        for (int k = 1; k < BG_D; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end
    assign w_bg_al = r_pipe[BG_D-1];
  end

  // Frame-latched enable mask.
  logic                r_vblnk_d;
  logic                r_frame_start;
  logic [N_LAYERS-1:0] r_en_active;
  logic                w_vblnk_rise;

  assign w_vblnk_rise = vblnk_in & ~r_vblnk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vblnk_d     <= 1'b0;
      r_frame_start <= 1'b0;
      r_en_active   <= EN_RESET;
    end else begin
      r_vblnk_d     <= vblnk_in;
      r_frame_start <= w_vblnk_rise;
      if (w_vblnk_rise) r_en_active <= layer_en_req;
    end
  end

  // Per-layer alignment and opacity.
  logic [RGB_W-1:0]    w_lrgb [N_LAYERS];
  logic [N_LAYERS-1:0] w_lvalid;
  logic [N_LAYERS-1:0] w_opaque;

  for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
    localparam int LAT = int'(LAYER_LAT[3*gi +: 3]);
    localparam int D   = MAX_LAT - LAT;

    logic [RGB_W:0] w_src;
    assign w_src = {layer_valid[gi], layer_rgb[gi*RGB_W +: RGB_W]};

    if (LAT > MAX_LAT) begin : g_bad_lat
      $error("vga_layer_mixer: LAYER_LAT of layer %0d exceeds MAX_LAT", gi);
    end

    if (D <= 0) begin : g_wire
      assign {w_lvalid[gi], w_lrgb[gi]} = w_src;
    end else begin : g_pipe
      logic [RGB_W:0] r_pipe [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < D; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= w_src;
          for (int k = 1; k < D; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign {w_lvalid[gi], w_lrgb[gi]} = r_pipe[D-1];
    end

    assign w_opaque[gi] = w_lvalid[gi] && r_en_active[gi] &&
                          !(KEY_EN && (w_lrgb[gi] == KEY_COLOR));
  end

  // Priority resolve: later (higher-index) opaque layers override earlier ones.
  logic [RGB_W-1:0] w_rgb_nxt;
  logic [ID_W-1:0]  w_id_nxt;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_rgb_nxt = w_bg_al;
    w_id_nxt  = ID_W'(N_LAYERS);
    for (int i = 0; i < N_LAYERS; i++) begin
      if (w_opaque[i]) begin
        w_rgb_nxt = w_lrgb[i];
        w_id_nxt  = ID_W'(i);
      end
    end
    if (w_tim_al[1] || w_tim_al[0]) begin
      w_rgb_nxt = '0;
      w_id_nxt  = ID_W'(N_LAYERS);
    end
  end

  // Compositing register stage.
  logic [TW-1:0]    r_tim_out;
  logic [RGB_W-1:0] r_rgb;
  logic [ID_W-1:0]  r_top_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tim_out <= '0;
      r_rgb     <= '0;
      r_top_id  <= ID_W'(N_LAYERS);
    end else begin
      r_tim_out <= w_tim_al;
      r_rgb     <= w_rgb_nxt;
      r_top_id  <= w_id_nxt;
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = r_tim_out;
  assign rgb_out         = r_rgb;
  assign top_id          = r_top_id;
  assign layer_en_active = r_en_active;
  assign frame_start     = r_frame_start;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer: two instances (colour key on/off) share stimulus;
// each pixel carries its hand-computed expected result, checked when it emerges 4 cycles later.
module tb_vga_layer_mixer;

  // Layer i has latency i cycles.
  localparam logic [11:0] LAYER_LAT = {3'd3, 3'd2, 3'd1, 3'd0};

  logic        clk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] bg_rgb;
  logic [47:0] layer_rgb;
  logic [3:0]  layer_valid;
  logic [3:0]  layer_en_req;

  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [2:0]  top_id;
  logic [3:0]  layer_en_active;
  logic        frame_start;

  logic [10:0] nk_hcount_out, nk_vcount_out;
  logic        nk_hsync_out, nk_vsync_out, nk_hblnk_out, nk_vblnk_out;
  logic [11:0] nk_rgb_out;
  logic [2:0]  nk_top_id;
  logic [3:0]  nk_layer_en_active;
  logic        nk_frame_start;

  vga_layer_mixer #(
    .N_LAYERS(4), .RGB_W(12), .CNT_W(11), .MAX_LAT(3), .LAYER_LAT(LAYER_LAT),
    .BG_LAT(0), .KEY_EN(1'b1), .KEY_COLOR(12'h0F0), .EN_RESET(4'b1111)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .bg_rgb(bg_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .layer_en_req(layer_en_req),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .top_id(top_id),
    .layer_en_active(layer_en_active), .frame_start(frame_start)
  );

  vga_layer_mixer #(
    .N_LAYERS(4), .RGB_W(12), .CNT_W(11), .MAX_LAT(3), .LAYER_LAT(LAYER_LAT),
    .BG_LAT(0), .KEY_EN(1'b0), .KEY_COLOR(12'h0F0), .EN_RESET(4'b1111)
  ) dut_nk (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .bg_rgb(bg_rgb), .layer_rgb(layer_rgb), .layer_valid(layer_valid),
    .layer_en_req(layer_en_req),
    .hcount_out(nk_hcount_out), .vcount_out(nk_vcount_out),
    .hsync_out(nk_hsync_out), .vsync_out(nk_vsync_out),
    .hblnk_out(nk_hblnk_out), .vblnk_out(nk_vblnk_out),
    .rgb_out(nk_rgb_out), .top_id(nk_top_id),
    .layer_en_active(nk_layer_en_active), .frame_start(nk_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] bg;
    logic [47:0] rgb;
    logic [3:0]  valid;
    logic [11:0] er;   // expected rgb, key enabled
    logic [2:0]  ei;   // expected top_id, key enabled
    logic [11:0] enr;  // expected rgb, key disabled
    logic [2:0]  eni;  // expected top_id, key disabled
    logic        chk;
  } pix_t;

  pix_t hist [4];
  logic chk_en;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t mk(input logic [10:0] h, input logic [10:0] v,
                              input logic hb, input logic vb, input logic [11:0] bg);
    pix_t p = '0;
    p.h = h; p.v = v; p.hs = h[0]; p.vs = v[0]; p.hb = hb; p.vb = vb; p.bg = bg;
    p.ei = 3'd4; p.eni = 3'd4; p.chk = 1'b1;
    return p;
  endfunction

  function automatic pix_t lay(input pix_t p, input int i, input logic [11:0] c);
    pix_t q = p;
    q.rgb[i*12 +: 12] = c;
    q.valid[i] = 1'b1;
    return q;
  endfunction

  function automatic pix_t ex(input pix_t p, input logic [11:0] r, input logic [2:0] id,
                              input logic [11:0] rn, input logic [2:0] idn);
    pix_t q = p;
    q.er = r; q.ei = id; q.enr = rn; q.eni = idn;
    return q;
  endfunction

  // Timing and background come from the newest pixel; layer i from the pixel i cycles old.
  task automatic drive();
    hcount_in = hist[0].h;  vcount_in = hist[0].v;
    hsync_in  = hist[0].hs; vsync_in  = hist[0].vs;
    hblnk_in  = hist[0].hb; vblnk_in  = hist[0].vb;
    bg_rgb    = hist[0].bg;
    for (int i = 0; i < 4; i++) begin
      layer_rgb[i*12 +: 12] = hist[i].rgb[i*12 +: 12];
      layer_valid[i]        = hist[i].valid[i];
    end
  endtask

  task automatic cycle(input pix_t p);
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = p;
    drive();
    @(negedge clk);
    if (chk_en && hist[3].chk) begin
      check("hcount_out", 32'(hcount_out), 32'(hist[3].h));
      check("vcount_out", 32'(vcount_out), 32'(hist[3].v));
      check("hsync_out",  32'(hsync_out),  32'(hist[3].hs));
      check("vsync_out",  32'(vsync_out),  32'(hist[3].vs));
      check("hblnk_out",  32'(hblnk_out),  32'(hist[3].hb));
      check("vblnk_out",  32'(vblnk_out),  32'(hist[3].vb));
      check("rgb_out",    32'(rgb_out),    32'(hist[3].er));
      check("top_id",     32'(top_id),     32'(hist[3].ei));
      check("nokey_rgb",  32'(nk_rgb_out), 32'(hist[3].enr));
      check("nokey_id",   32'(nk_top_id),  32'(hist[3].eni));
      check("nokey_hcount", 32'(nk_hcount_out), 32'(hist[3].h));
    end
  endtask

  task automatic flush_hist();
    for (int k = 0; k < 4; k++) hist[k] = mk(11'd0, 11'd0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    pix_t p;
    chk_en = 1'b0;
    rst = 1'b1;
    layer_en_req = 4'b1111;
    flush_hist();
    drive();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_rgb",     32'(rgb_out),         32'h0);
    check("rst_top_id",  32'(top_id),          32'd4);
    check("rst_mask",    32'(layer_en_active), 32'hF);
    check("rst_fstart",  32'(frame_start),     32'h0);
    check("rst_hcount",  32'(hcount_out),      32'h0);
    check("rst_hsync",   32'(hsync_out),       32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Alignment: layer i colour = {i, hcount[7:0]}; layer 3 always wins
    for (int h = 96; h <= 106; h++) begin
      p = mk(11'(h), 11'd10, 1'b0, 1'b0, 12'h555);
      for (int i = 0; i < 4; i++) p = lay(p, i, {4'(i), 8'(h)});
      p = ex(p, {4'h3, 8'(h)}, 3'd3, {4'h3, 8'(h)}, 3'd3);
      cycle(p);
    end
    for (int h = 107; h <= 110; h++) cycle(mk(11'(h), 11'd10, 1'b1, 1'b0, 12'h555));

    // Priority
    p = lay(lay(mk(11'd200, 11'd20, 1'b0, 1'b0, 12'h123), 0, 12'hF00), 2, 12'h00F);
    cycle(ex(p, 12'h00F, 3'd2, 12'h00F, 3'd2));
    p = lay(mk(11'd201, 11'd20, 1'b0, 1'b0, 12'h123), 0, 12'hF00);
    cycle(ex(p, 12'hF00, 3'd0, 12'hF00, 3'd0));
    p = mk(11'd202, 11'd20, 1'b0, 1'b0, 12'h123);
    cycle(ex(p, 12'h123, 3'd4, 12'h123, 3'd4));

    // Colour key
    p = lay(lay(mk(11'd210, 11'd20, 1'b0, 1'b0, 12'h321), 3, 12'h0F0), 1, 12'hABC);
    cycle(ex(p, 12'hABC, 3'd1, 12'h0F0, 3'd3));
    p = lay(mk(11'd211, 11'd20, 1'b0, 1'b0, 12'h321), 3, 12'h0F0);
    cycle(ex(p, 12'h321, 3'd4, 12'h0F0, 3'd3));
    p = lay(lay(mk(11'd212, 11'd20, 1'b0, 1'b0, 12'h321), 1, 12'h0F0), 0, 12'h456);
    cycle(ex(p, 12'h456, 3'd0, 12'h0F0, 3'd1));

    // Horizontal blanking between two visible pixels
    p = lay(mk(11'd219, 11'd20, 1'b0, 1'b0, 12'h321), 2, 12'h222);
    cycle(ex(p, 12'h222, 3'd2, 12'h222, 3'd2));
    p = mk(11'd220, 11'd20, 1'b1, 1'b0, 12'h321);
    for (int i = 0; i < 4; i++) p = lay(p, i, 12'hFFF);
    cycle(p);
    p = lay(mk(11'd221, 11'd20, 1'b0, 1'b0, 12'h321), 2, 12'h222);
    cycle(ex(p, 12'h222, 3'd2, 12'h222, 3'd2));

    // Mid-frame mask request has no effect on the rest of the frame
    layer_en_req = 4'b0001;
    for (int h = 230; h <= 231; h++) begin
      p = mk(11'(h), 11'd300, 1'b0, 1'b0, 12'h0AA);
      for (int i = 0; i < 4; i++) p = lay(p, i, 12'(12'h111 * (i + 1)));
      cycle(ex(p, 12'h444, 3'd3, 12'h444, 3'd3));
    end
    check("mid_mask",   32'(layer_en_active), 32'hF);
    check("mid_fstart", 32'(frame_start),     32'h0);
    for (int h = 232; h <= 235; h++) cycle(mk(11'(h), 11'd300, 1'b1, 1'b0, 12'h0AA));

    // Vertical blank rising edge latches the mask
    p = mk(11'd0, 11'd600, 1'b1, 1'b1, 12'h0AA);
    for (int i = 0; i < 4; i++) p = lay(p, i, 12'hFFF);
    cycle(p);
    check("vb_fstart",    32'(frame_start),        32'h1);
    check("vb_mask",      32'(layer_en_active),    32'h1);
    check("vb_nk_fstart", 32'(nk_frame_start),     32'h1);
    check("vb_nk_mask",   32'(nk_layer_en_active), 32'h1);
    layer_en_req = 4'b1111;
    cycle(mk(11'd1, 11'd600, 1'b1, 1'b1, 12'h0AA));
    check("vb_fstart_end", 32'(frame_start), 32'h0);
    cycle(mk(11'd2, 11'd600, 1'b1, 1'b1, 12'h0AA));
    check("vb_mask_hold",  32'(layer_en_active), 32'h1);
    for (int h = 3; h <= 6; h++) cycle(mk(11'(h), 11'd0, 1'b1, 1'b0, 12'h0AA));

    // New frame: only layer 0 or background visible
    p = mk(11'd230, 11'd0, 1'b0, 1'b0, 12'h0AA);
    for (int i = 0; i < 4; i++) p = lay(p, i, 12'(12'h111 * (i + 1)));
    cycle(ex(p, 12'h111, 3'd0, 12'h111, 3'd0));
    p = lay(mk(11'd231, 11'd0, 1'b0, 1'b0, 12'h0AA), 3, 12'h444);
    cycle(ex(p, 12'h0AA, 3'd4, 12'h0AA, 3'd4));
    for (int h = 232; h <= 235; h++) cycle(mk(11'(h), 11'd0, 1'b1, 1'b0, 12'h0AA));
    check("frame_mask", 32'(layer_en_active), 32'h1);

    // Request change in the same cycle as the vblnk rising edge
    layer_en_req = 4'b1000;
    cycle(mk(11'd0, 11'd600, 1'b1, 1'b1, 12'h0AA));
    check("sim_fstart", 32'(frame_start),     32'h1);
    check("sim_mask",   32'(layer_en_active), 32'h8);
    for (int h = 1; h <= 4; h++) cycle(mk(11'(h), 11'd5, 1'b1, 1'b0, 12'h0AA));
    p = mk(11'd240, 11'd5, 1'b0, 1'b0, 12'h0BB);
    for (int i = 0; i < 4; i++) p = lay(p, i, 12'(12'h111 * (i + 1)));
    cycle(ex(p, 12'h444, 3'd3, 12'h444, 3'd3));
    p = lay(mk(11'd241, 11'd5, 1'b0, 1'b0, 12'h0BB), 0, 12'h111);
    cycle(ex(p, 12'h0BB, 3'd4, 12'h0BB, 3'd4));

    // Asynchronous reset mid-line
    for (int h = 400; h <= 403; h++) begin
      p = lay(lay(mk(11'(h), 11'd6, 1'b0, 1'b0, 12'h0CC), 3, 12'h777), 0, 12'h111);
      cycle(ex(p, 12'h777, 3'd3, 12'h777, 3'd3));
    end
    #2;
    rst = 1'b1;
    #1;
    check("arst_rgb",    32'(rgb_out),         32'h0);
    check("arst_top_id", 32'(top_id),          32'd4);
    check("arst_mask",   32'(layer_en_active), 32'hF);
    check("arst_hcount", 32'(hcount_out),      32'h0);
    check("arst_nk_rgb", 32'(nk_rgb_out),      32'h0);
    chk_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush_hist();
    chk_en = 1'b1;
    for (int h = 410; h <= 415; h++) begin
      p = lay(lay(mk(11'(h), 11'd6, 1'b0, 1'b0, 12'h0CC), 3, 12'h777), 0, 12'h111);
      cycle(ex(p, 12'h777, 3'd3, 12'h777, 3'd3));
    end
    check("post_rst_mask", 32'(layer_en_active), 32'hF);
    for (int h = 416; h <= 419; h++) cycle(mk(11'(h), 11'd6, 1'b1, 1'b0, 12'h0CC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised N-layer VGA compositor that replaces the hand-chained per-layer vga_if pass-through.
- Takes raw timing (hcount/vcount/sync/blank), a background colour and N layer pixels, each with its own fixed pipeline latency.
- Aligns the layer pixels internally, resolves priority and colour-key transparency, and outputs the composited pixel with delayed timing.
- The layer-enable mask is latched once per frame, so a layer never switches on or off mid-screen.

Parameters:
N_LAYERS, 4, number of overlay layers; layer N_LAYERS-1 has top priority
RGB_W, 12, pixel colour width
CNT_W, 11, hcount/vcount width
MAX_LAT, 3, largest supported layer/background latency in cycles (1..7)
LAYER_LAT, {N_LAYERS{3'd0}}, packed 3-bit latency per layer; layer i occupies bits [3i+2:3i]
BG_LAT, 0, latency of bg_rgb relative to timing inputs
KEY_EN, 1, enable colour-key transparency
KEY_COLOR, 12'h0F0, colour treated as transparent when KEY_EN=1
EN_RESET, all ones, layer_en_active value after reset

Ports:
clk  in  1  system clock (65 MHz pixel clock)
rst  in  1  asynchronous active-high reset
hcount_in  in  CNT_W  horizontal count from vga_timing
vcount_in  in  CNT_W  vertical count
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
bg_rgb  in  RGB_W  background pixel, valid BG_LAT cycles after matching timing
layer_rgb  in  N_LAYERS*RGB_W  packed layer pixels; layer i occupies bits [i*RGB_W +: RGB_W]
layer_valid  in  N_LAYERS  layer i pixel is opaque candidate, aligned with layer_rgb
layer_en_req  in  N_LAYERS  requested enable mask (e.g. from game_fsm state)
hcount_out  out  CNT_W  delayed hcount
vcount_out  out  CNT_W  delayed vcount
hsync_out  out  1  delayed hsync
vsync_out  out  1  delayed vsync
hblnk_out  out  1  delayed hblnk
vblnk_out  out  1  delayed vblnk
rgb_out  out  RGB_W  composited pixel
top_id  out  $clog2(N_LAYERS+1)  winning layer index; N_LAYERS means background won
layer_en_active  out  N_LAYERS  currently applied enable mask
frame_start  out  1  one-cycle pulse when the mask is latched

Behaviour:
- Reset (async, rst=1):
  - All timing outputs, rgb_out, frame_start = 0.
  - top_id = N_LAYERS.
  - layer_en_active = EN_RESET.
  - All delay-line contents = 0.
- Total latency: every timing output equals its input delayed exactly MAX_LAT+1 cycles.
- Alignment:
  - Layer i data is delayed by MAX_LAT-LAYER_LAT[i] register stages (0 stages = wire).
  - Background is delayed by MAX_LAT-BG_LAT stages.
  - All sources then reach one compositing register stage together with the timing delayed by MAX_LAT.
- Opaque condition for layer i: layer_valid_aligned[i] && layer_en_active[i] && !(KEY_EN && rgb_aligned_i==KEY_COLOR).
- Priority: the highest-index opaque layer wins. If no layer is opaque, the background wins and top_id=N_LAYERS.
- Blanking: if aligned hblnk or vblnk = 1, rgb_out=0 and top_id=N_LAYERS, regardless of layer data.
- Mask latch:
  - On a rising edge of vblnk_in (detected with a registered copy), layer_en_active <= layer_en_req, and frame_start pulses high for exactly 1 cycle.
  - Changes to layer_en_req at any other time have no effect until the next rising edge.
  - The new mask applies to pixels whose aligned timing arrives after the latch.
  - Since this happens during blanking, no visible pixel within a frame uses a mixed mask.
- Simultaneous change: if layer_en_req changes in the same cycle as the vblnk rising edge, the value sampled on that edge is used.
- Reset mid-frame:
  - Outputs go to reset values immediately.
  - After release, the pipeline refills and timing outputs are valid MAX_LAT+1 cycles later.
  - The mask stays at EN_RESET until the next vblnk rising edge.
- Elaboration constraints: any LAYER_LAT[i] or BG_LAT > MAX_LAT is an error, enforced with $error at elaboration.

Test Plan:
1. Alignment (N_LAYERS=4, MAX_LAT=3, LAYER_LAT={3,2,1,0}): layer i is driven with an hcount-derived colour at its own latency -> rgb_out at hcount_out=100 equals the colour layer 3 presented for hcount 100. All timing outputs lag inputs by exactly 4 cycles.
2. Priority: layers 0 and 2 valid at the same pixel with colours 12'hF00 and 12'h00F -> rgb_out=12'h00F, top_id=2. Layer 2 then not valid -> rgb_out=12'hF00, top_id=0.
3. Colour key: layer 3 valid with rgb 12'h0F0 over layer 1 at 12'hABC -> rgb_out=12'hABC, top_id=1. Repeat with KEY_EN=0 -> rgb_out=12'h0F0, top_id=3.
4. Frame-latched mask: layer_en_req toggled from 4'b1111 to 4'b0001 at mid-frame vcount=300 -> rest of frame unchanged. On vblnk rising edge, frame_start pulses 1 cycle; the next frame shows only layer 0 or background.
5. Blanking: any layer valid while hblnk_in=1 -> rgb_out=0, top_id=4, exactly 4 cycles after the blank.
6. Async reset mid-line: assert rst during active video -> rgb_out=0 and layer_en_active=4'b1111 immediately. After release, outputs track the inputs again after 4 cycles.
